// File: rtl/basket_controller.sv
// Basket storage and pricing engine: keeps an ordered, packed list of (id, qty)
// entries, merges repeated IDs, compacts on cancel and recomputes the total.
module basket_controller #(
    parameter int DEPTH   = 8,
    parameter int QTY_MAX = 7
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic       Clear,
    input  logic       Add_En,
    input  logic [2:0] ProductID_in,
    input  logic [2:0] ProductQuantity_in,
    input  logic       Cancel_En,
    input  logic [2:0] Cancel_Index,
    input  logic [2:0] Read_Index,
    output logic [2:0] Read_ProductID,
    output logic [2:0] Read_Quantity,
    output logic       Read_Valid,
    output logic [3:0] NumEntries,
    output logic       Full,
    output logic       Empty,
    output logic       Busy,
    output logic [9:0] Total,
    output logic       Error
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_SUM   = 2'd2;

    function automatic logic [3:0] price(input logic [2:0] id);
        case (id)
            3'd0:    price = 4'd2;
            3'd1:    price = 4'd3;
            3'd2:    price = 4'd5;
            3'd3:    price = 4'd7;
            3'd4:    price = 4'd1;
            3'd5:    price = 4'd4;
            3'd6:    price = 4'd6;
            default: price = 4'd8;
        endcase
    endfunction

    logic [1:0] state_q, state_d;
    logic [2:0] id_q  [DEPTH];
    logic [2:0] id_d  [DEPTH];
    logic [2:0] qty_q [DEPTH];
    logic [2:0] qty_d [DEPTH];
    logic [3:0] num_q, num_d;
    logic [9:0] total_q, total_d;
    logic [9:0] acc_q, acc_d;
    logic [2:0] ptr_q, ptr_d;
    logic [3:0] idx_q, idx_d;
    logic       err_q, err_d;

    logic       hit;
    logic [2:0] hit_k;
    logic [3:0] merged;
    logic       qty_ok;
    logic [6:0] term;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        id_d    = id_q;
        qty_d   = qty_q;
        num_d   = num_q;
        total_d = total_q;
        acc_d   = acc_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        err_d   = 1'b0;
        hit     = 1'b0;
        hit_k   = 3'd0;

        for (int k = 0; k < DEPTH; k++) begin
            if (!hit && (4'(k) < num_q) && (id_q[k] == ProductID_in)) begin
                hit   = 1'b1;
                hit_k = 3'(k);
            end
        end
        merged = {1'b0, qty_q[hit_k]} + {1'b0, ProductQuantity_in};
        qty_ok = (ProductQuantity_in != 3'd0) && (ProductQuantity_in <= 3'd4);
        term   = {3'b000, price(id_q[idx_q[2:0]])} * {4'b0000, qty_q[idx_q[2:0]]};

        if (Clear) begin
            state_d = S_IDLE;
            num_d   = 4'd0;
            total_d = 10'd0;
            acc_d   = 10'd0;
            idx_d   = 4'd0;
            for (int k = 0; k < DEPTH; k++) begin
                id_d[k]  = 3'd0;
                qty_d[k] = 3'd0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (Cancel_En) begin
                        // A simultaneous add is always dropped and flagged.
                        err_d = Add_En;
                        if ({1'b0, Cancel_Index} >= num_q) begin
                            err_d = 1'b1;
                        end else begin
                            state_d = S_SHIFT;
                            ptr_d   = Cancel_Index;
                        end
                    end else if (Add_En) begin
                        if (!qty_ok) begin
                            err_d = 1'b1;
                        end else if (hit) begin
                            qty_d[hit_k] = (merged > 4'(QTY_MAX)) ? 3'(QTY_MAX) : merged[2:0];
                            state_d = S_SUM;
                            acc_d   = 10'd0;
                            idx_d   = 4'd0;
                        end else if (num_q == 4'(DEPTH)) begin
                            err_d = 1'b1;
                        end else begin
                            id_d[num_q[2:0]]  = ProductID_in;
                            qty_d[num_q[2:0]] = ProductQuantity_in;
                            num_d   = num_q + 4'd1;
                            state_d = S_SUM;
                            acc_d   = 10'd0;
                            idx_d   = 4'd0;
                        end
                    end
                end
                S_SHIFT: begin
                    err_d = Add_En | Cancel_En;
                    if (({1'b0, ptr_q} + 4'd1) < num_q) begin
                        id_d[ptr_q]  = id_q[ptr_q + 3'd1];
                        qty_d[ptr_q] = qty_q[ptr_q + 3'd1];
                    end
                    // The last move and the tail clear share one cycle.
                    if (({1'b0, ptr_q} + 4'd2) >= num_q) begin
                        id_d[3'(num_q - 4'd1)]  = 3'd0;
                        qty_d[3'(num_q - 4'd1)] = 3'd0;
                        num_d   = num_q - 4'd1;
                        state_d = S_SUM;
                        acc_d   = 10'd0;
                        idx_d   = 4'd0;
                    end else begin
                        ptr_d = ptr_q + 3'd1;
                    end
                end
                S_SUM: begin
                    err_d = Add_En | Cancel_En;
                    if (idx_q < num_q) begin
                        acc_d = acc_q + {3'b000, term};
                        idx_d = idx_q + 4'd1;
                    end else begin
                        total_d = acc_q;
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            state_q <= S_IDLE;
            // NOTE: the entry file is reset because empty slots must read back as zero.
            for (int k = 0; k < DEPTH; k++) begin
                id_q[k]  <= 3'd0;
                qty_q[k] <= 3'd0;
            end
            num_q   <= 4'd0;
            total_q <= 10'd0;
            acc_q   <= 10'd0;
            ptr_q   <= 3'd0;
            idx_q   <= 4'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            qty_q   <= qty_d;
            num_q   <= num_d;
            total_q <= total_d;
            acc_q   <= acc_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
        end
    end

    assign Read_ProductID = id_q[Read_Index];
    assign Read_Quantity  = qty_q[Read_Index];
    assign Read_Valid     = ({1'b0, Read_Index} < num_q);
    assign NumEntries     = num_q;
    assign Full           = (num_q == 4'(DEPTH));
    assign Empty          = (num_q == 4'd0);
    assign Busy           = (state_q != S_IDLE);
    assign Total          = total_q;
    assign Error          = err_q;

endmodule

// File: tb/tb_basket_controller.sv
// Scoreboard bench for basket_controller: stimulus queues expected completions
// and error pulses; a monitor pops them whenever Busy falls or Error pulses.
module tb_basket_controller;

    logic       CLOCK_50 = 1'b0;
    logic       RESET_N;
    logic       Clear, Add_En, Cancel_En;
    logic [2:0] ProductID_in, ProductQuantity_in, Cancel_Index, Read_Index;
    logic [2:0] Read_ProductID, Read_Quantity;
    logic       Read_Valid, Full, Empty, Busy, Error;
    logic [3:0] NumEntries;
    logic [9:0] Total;

    always #5 CLOCK_50 = ~CLOCK_50;

    basket_controller dut (
        .CLOCK_50           (CLOCK_50),
        .RESET_N            (RESET_N),
        .Clear              (Clear),
        .Add_En             (Add_En),
        .ProductID_in       (ProductID_in),
        .ProductQuantity_in (ProductQuantity_in),
        .Cancel_En          (Cancel_En),
        .Cancel_Index       (Cancel_Index),
        .Read_Index         (Read_Index),
        .Read_ProductID     (Read_ProductID),
        .Read_Quantity      (Read_Quantity),
        .Read_Valid         (Read_Valid),
        .NumEntries         (NumEntries),
        .Full               (Full),
        .Empty              (Empty),
        .Busy               (Busy),
        .Total              (Total),
        .Error              (Error)
    );

    typedef struct {
        int busy;
        int total;
        int num;
    } exp_t;

    exp_t done_q[$];
    exp_t err_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // Monitor: consumes one expectation per Error pulse and per Busy fall.
    initial begin
        int   busy_cnt;
        logic prev_busy;
        exp_t e;
        busy_cnt  = 0;
        prev_busy = 1'b0;
        forever begin
            @(negedge CLOCK_50);
            if (Error === 1'b1) begin
                if (err_q.size() == 0) begin
                    fail("unexpected_error_pulse");
                end else begin
                    e = err_q.pop_front();
                    check("err_num", int'(NumEntries), e.num);
                    check("err_total", int'(Total), e.total);
                end
            end
            if (Busy === 1'b1) begin
                busy_cnt++;
            end else if (prev_busy) begin
                if (done_q.size() == 0) begin
                    fail("unexpected_busy_fall");
                end else begin
                    e = done_q.pop_front();
                    check("busy_cycles", busy_cnt, e.busy);
                    check("done_total", int'(Total), e.total);
                    check("done_num", int'(NumEntries), e.num);
                end
                busy_cnt = 0;
            end
            prev_busy = (Busy === 1'b1);
        end
    end

    task automatic expect_done(input int b, input int t, input int n);
        exp_t e;
        e.busy = b; e.total = t; e.num = n;
        done_q.push_back(e);
    endtask

    task automatic expect_err(input int n, input int t);
        exp_t e;
        e.busy = 0; e.total = t; e.num = n;
        err_q.push_back(e);
    endtask

    task automatic cmd(input logic clr, input logic add, input int id, input int q,
                       input logic cancel, input int ci);
        @(negedge CLOCK_50);
        Clear              = clr;
        Add_En             = add;
        ProductID_in       = 3'(id);
        ProductQuantity_in = 3'(q);
        Cancel_En          = cancel;
        Cancel_Index       = 3'(ci);
        @(negedge CLOCK_50);
        Clear     = 1'b0;
        Add_En    = 1'b0;
        Cancel_En = 1'b0;
    endtask

    task automatic add(input int id, input int q);
        cmd(1'b0, 1'b1, id, q, 1'b0, 0);
    endtask

    task automatic cancel(input int ci);
        cmd(1'b0, 1'b0, 0, 0, 1'b1, ci);
    endtask

    task automatic clear();
        cmd(1'b1, 1'b0, 0, 0, 1'b0, 0);
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge CLOCK_50);
            if (done_q.size() == 0 && err_q.size() == 0 && Busy === 1'b0) begin
                done = 1'b1;
                break;
            end
        end
        @(negedge CLOCK_50);
        if (!done) begin
            fail("drain_timeout");
            done_q.delete();
            err_q.delete();
        end
    endtask

    task automatic read_chk(input int idx, input int eid, input int eq, input int ev);
        Read_Index = 3'(idx);
        #1;
        check($sformatf("read_id[%0d]", idx), int'(Read_ProductID), eid);
        check($sformatf("read_qty[%0d]", idx), int'(Read_Quantity), eq);
        check($sformatf("read_valid[%0d]", idx), int'(Read_Valid), ev);
    endtask

    task automatic reset_chk(input string tag);
        check({tag, "_num"}, int'(NumEntries), 0);
        check({tag, "_total"}, int'(Total), 0);
        check({tag, "_busy"}, int'(Busy), 0);
        check({tag, "_error"}, int'(Error), 0);
        check({tag, "_empty"}, int'(Empty), 1);
        check({tag, "_full"}, int'(Full), 0);
    endtask

    int cum[8] = '{2, 5, 10, 17, 18, 22, 28, 36};

    initial begin
        RESET_N = 1'b0;
        Clear = 1'b0; Add_En = 1'b0; Cancel_En = 1'b0;
        ProductID_in = '0; ProductQuantity_in = '0; Cancel_Index = '0; Read_Index = '0;
        repeat (2) @(negedge CLOCK_50);
        reset_chk("reset");
        read_chk(0, 0, 0, 0);
        RESET_N = 1'b1;

        // Single add: ID3 x2 -> 7*2
        expect_done(2, 14, 1);
        add(3, 2);
        drain();
        read_chk(0, 3, 2, 1);
        read_chk(1, 0, 0, 0);

        // Merge with saturation at 7
        clear();
        drain();
        check("clear_num", int'(NumEntries), 0);
        check("clear_total", int'(Total), 0);
        expect_done(2, 28, 1);
        add(3, 4);
        drain();
        expect_done(2, 49, 1);
        add(3, 4);
        drain();
        read_chk(0, 3, 7, 1);

        // Fill with IDs 0..7 at qty 1
        clear();
        drain();
        for (int k = 0; k < 8; k++) begin
            expect_done(k + 2, cum[k], k + 1);
            add(k, 1);
            drain();
        end
        check("full_flag", int'(Full), 1);
        check("full_empty", int'(Empty), 0);
        read_chk(7, 7, 1, 1);
        // Existing ID still merges while full: qty 1+2, total 36+4*2
        expect_done(9, 44, 8);
        add(5, 2);
        drain();
        read_chk(5, 5, 3, 1);

        // Build (1,1),(2,2),(5,3): totals 3, 13, 25
        clear();
        drain();
        expect_done(2, 3, 1);
        add(1, 1);
        drain();
        expect_done(3, 13, 2);
        add(2, 2);
        drain();
        expect_done(4, 25, 3);
        add(5, 3);
        drain();
        // Rejections: index at count, qty 0, qty 5
        expect_err(3, 25);
        cancel(3);
        drain();
        expect_err(3, 25);
        add(6, 0);
        drain();
        expect_err(3, 25);
        add(6, 5);
        drain();
        // Cancel first entry: SHIFT 2 + SUM 3, total 5*2 + 4*3
        expect_done(5, 22, 2);
        cancel(0);
        drain();
        read_chk(0, 2, 2, 1);
        read_chk(1, 5, 3, 1);
        read_chk(2, 0, 0, 0);
        expect_err(2, 22);
        cancel(5);
        drain();

        // Cancel last entry (SHIFT 1 + SUM 2) with an add arriving while busy
        expect_done(3, 10, 1);
        expect_err(1, 22);
        cancel(1);
        add(7, 1);
        drain();
        read_chk(0, 2, 2, 1);

        // Cancel and add together: cancel wins, add flagged, basket empties
        expect_err(1, 10);
        expect_done(2, 0, 0);
        cmd(1'b0, 1'b1, 4, 1, 1'b1, 0);
        drain();
        check("empty_after_cancel", int'(Empty), 1);

        // Clear in the middle of SUM
        expect_done(2, 16, 1);
        add(7, 2);
        drain();
        expect_done(3, 22, 2);
        add(6, 1);
        drain();
        expect_done(2, 0, 0);
        add(0, 4);
        clear();
        drain();
        check("midsum_clear_num", int'(NumEntries), 0);
        check("midsum_clear_total", int'(Total), 0);
        check("midsum_clear_busy", int'(Busy), 0);

        // Reset in the middle of SHIFT
        expect_done(2, 3, 1);
        add(1, 1);
        drain();
        expect_done(3, 13, 2);
        add(2, 2);
        drain();
        expect_done(4, 25, 3);
        add(5, 3);
        drain();
        expect_done(1, 0, 0);
        cancel(0);
        RESET_N = 1'b0;
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        reset_chk("midshift_reset");
        read_chk(0, 0, 0, 0);
        read_chk(1, 0, 0, 0);
        RESET_N = 1'b1;
        drain();

        check("leftover_done", done_q.size(), 0);
        check("leftover_err", err_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
